// File: rtl/vga_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_pkg
// Description : Shared screen geometry, colour and state types for the
//               pixel-colour source feeding the 640x480 VGA timing stage.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_pkg;

    localparam int HPIXELS = 640;
    localparam int VPIXELS = 480;

    // Direction encoding for one axis of motion
    localparam logic DIR_POS = 1'b0;
    localparam logic DIR_NEG = 1'b1;

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } color8_t;

    typedef enum logic {
        MOVING = 1'b0,
        PAUSED = 1'b1
    } box_state_t;

    // True when lo <= v < lo + len; all operands are 11 bits so the sum
    // of a legal position and the box size never overflows.
    function automatic logic in_span(input logic [10:0] v,
                                     input logic [10:0] lo,
                                     input logic [10:0] len);
        return (v >= lo) && (v < (lo + len));
    endfunction

endpackage
`default_nettype wire

// File: rtl/box_renderer_axis_bounce.sv
`default_nettype none
// ============================================================================
// Module      : axis_bounce
// Description : Next position / direction for one axis of the bouncing
//               square. Purely combinational; clamps at 0 and MAX and
//               flags a wall hit when it does.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_bounce #(
    parameter int MAX   = 608,
    parameter int SPEED = 2
) (
    input  logic [10:0] i_pos,
    input  logic        i_dir,
    output logic [10:0] o_next_pos,
    output logic        o_next_dir,
    output logic        o_hit
);
    import vga_pkg::*;

    localparam logic [10:0] c_max   = 11'(MAX);
    localparam logic [10:0] c_speed = 11'(SPEED);

    // Step toward the current wall; land exactly on it and reverse on contact
    always_comb begin
        o_next_pos = i_pos;
        o_next_dir = i_dir;
        o_hit      = 1'b0;
        if (i_dir == DIR_POS) begin
            if ((i_pos + c_speed) >= c_max) begin
                o_next_pos = c_max;
                o_next_dir = DIR_NEG;
                o_hit      = 1'b1;
            end else begin
                o_next_pos = i_pos + c_speed;
            end
        end else begin
            if (i_pos <= c_speed) begin
                o_next_pos = 11'd0;
                o_next_dir = DIR_POS;
                o_hit      = 1'b1;
            end else begin
                o_next_pos = i_pos - c_speed;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/box_renderer.sv
`default_nettype none
// ============================================================================
// Module      : box_renderer
// Description : Pixel-colour source for the VGA timing stage. Draws a solid
//               square bouncing off the screen edges over a flat background.
//               Motion is applied once per frame at the start of vertical
//               blank so the visible image never tears.
// Revision    : 1.0 - initial release
// ============================================================================
module box_renderer #(
    parameter int         HPIXELS      = vga_pkg::HPIXELS,
    parameter int         VPIXELS      = vga_pkg::VPIXELS,
    parameter int         BOX_SIZE     = 32,
    parameter int         SPEED        = 2,
    parameter int         FLASH_FRAMES = 8,
    parameter logic [7:0] BG_COLOR     = 8'h02,
    parameter logic [7:0] BOX_COLOR    = 8'hE0,
    parameter logic [7:0] FLASH_COLOR  = 8'hFF
) (
    input  logic       vgaclk,
    input  logic       rst,
    input  logic [9:0] hc_in,
    input  logic [9:0] vc_in,
    input  logic       pause,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic       frame_tick,
    output logic [7:0] bounce_count
);
    import vga_pkg::*;

    localparam logic [9:0]  c_vblank = 10'(VPIXELS);
    localparam logic [10:0] c_hpix   = 11'(HPIXELS);
    localparam logic [10:0] c_vpix   = 11'(VPIXELS);
    localparam logic [10:0] c_box    = 11'(BOX_SIZE);
    localparam logic [7:0]  c_flash  = 8'(FLASH_FRAMES);

    box_state_t  state_q, state_d;
    logic [10:0] box_x_q, box_x_d;
    logic [10:0] box_y_q, box_y_d;
    logic        dir_x_q, dir_x_d;
    logic        dir_y_q, dir_y_d;
    logic [7:0]  flash_cnt_q, flash_cnt_d;
    logic [7:0]  bounce_count_q, bounce_count_d;
    logic [9:0]  prev_vc_q, prev_vc_d;
    logic        frame_tick_q, frame_tick_d;

    logic [10:0] nx_pos, ny_pos;
    logic        nx_dir, ny_dir;
    logic        hit_x, hit_y;
    logic        move_en;

    axis_bounce #(
        .MAX   (HPIXELS - BOX_SIZE),
        .SPEED (SPEED)
    ) u_axis_x (
        .i_pos      (box_x_q),
        .i_dir      (dir_x_q),
        .o_next_pos (nx_pos),
        .o_next_dir (nx_dir),
        .o_hit      (hit_x)
    );

    axis_bounce #(
        .MAX   (VPIXELS - BOX_SIZE),
        .SPEED (SPEED)
    ) u_axis_y (
        .i_pos      (box_y_q),
        .i_dir      (dir_y_q),
        .o_next_pos (ny_pos),
        .o_next_dir (ny_dir),
        .o_hit      (hit_y)
    );

    // Edge-detect the vertical counter entering the first blank line
    always_comb begin
        prev_vc_d    = vc_in;
        frame_tick_d = (vc_in == c_vblank) && (prev_vc_q != c_vblank);
    end

    // FSM next state: pause is only looked at on the frame tick
    always_comb begin
        state_d = state_q;
        if (frame_tick_q) begin
            state_d = pause ? PAUSED : MOVING;
        end
    end

    // The tick that lands in MOVING (including the resume tick) moves the square
    assign move_en = frame_tick_q && (state_d == MOVING);

    // Per-frame motion, hit counting and flash countdown
    always_comb begin
        box_x_d        = box_x_q;
        box_y_d        = box_y_q;
        dir_x_d        = dir_x_q;
        dir_y_d        = dir_y_q;
        flash_cnt_d    = flash_cnt_q;
        bounce_count_d = bounce_count_q;
        if (move_en) begin
            box_x_d = nx_pos;
            box_y_d = ny_pos;
            dir_x_d = nx_dir;
            dir_y_d = ny_dir;
        end
        // A corner hit counts once, and a reload beats the countdown
        if (move_en && (hit_x || hit_y)) begin
            flash_cnt_d    = c_flash;
            bounce_count_d = bounce_count_q + 8'd1;
        end else if (frame_tick_q && (flash_cnt_q != 8'd0)) begin
            flash_cnt_d = flash_cnt_q - 8'd1;
        end
    end

    // FSM state register
    always_ff @(posedge vgaclk) begin
        if (rst) begin
            state_q <= MOVING;
        end else begin
            state_q <= state_d;
        end
    end

    // Datapath registers
    always_ff @(posedge vgaclk) begin
        if (rst) begin
            box_x_q        <= 11'd0;
            box_y_q        <= 11'd0;
            dir_x_q        <= DIR_POS;
            dir_y_q        <= DIR_POS;
            flash_cnt_q    <= 8'd0;
            bounce_count_q <= 8'd0;
            prev_vc_q      <= 10'd0;
            frame_tick_q   <= 1'b0;
        end else begin
            box_x_q        <= box_x_d;
            box_y_q        <= box_y_d;
            dir_x_q        <= dir_x_d;
            dir_y_q        <= dir_y_d;
            flash_cnt_q    <= flash_cnt_d;
            bounce_count_q <= bounce_count_d;
            prev_vc_q      <= prev_vc_d;
            frame_tick_q   <= frame_tick_d;
        end
    end

    // Zero-latency colour mux from the live counters and registered state
    color8_t pix;
    logic [10:0] hc_w, vc_w;
    always_comb begin
        hc_w = {1'b0, hc_in};
        vc_w = {1'b0, vc_in};
        pix  = color8_t'(BG_COLOR);
        if ((hc_w >= c_hpix) || (vc_w >= c_vpix)) begin
            pix = color8_t'(8'h00);
        end else if (in_span(hc_w, box_x_q, c_box) && in_span(vc_w, box_y_q, c_box)) begin
            pix = (flash_cnt_q != 8'd0) ? color8_t'(FLASH_COLOR) : color8_t'(BOX_COLOR);
        end
    end

    assign red          = pix.r;
    assign green        = pix.g;
    assign blue         = pix.b;
    assign frame_tick   = frame_tick_q;
    assign bounce_count = bounce_count_q;

endmodule
`default_nettype wire

// File: tb/tb_box_renderer.sv
`default_nettype none
// ============================================================================
// Module      : tb_box_renderer
// Description : Directed self-checking bench for box_renderer. A second
//               instance on a square 480x480 screen exercises the corner hit.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_box_renderer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [9:0] hc  = 10'd0;
    logic [9:0] vc  = 10'd0;
    logic       pause = 1'b0;

    logic [2:0] red1, green1, red2, green2;
    logic [1:0] blue1, blue2;
    logic       tick1, tick2;
    logic [7:0] bounce1, bounce2;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    box_renderer dut1 (
        .vgaclk       (clk),
        .rst          (rst),
        .hc_in        (hc),
        .vc_in        (vc),
        .pause        (pause),
        .red          (red1),
        .green        (green1),
        .blue         (blue1),
        .frame_tick   (tick1),
        .bounce_count (bounce1)
    );

    box_renderer #(
        .HPIXELS (480),
        .VPIXELS (480)
    ) dut2 (
        .vgaclk       (clk),
        .rst          (rst),
        .hc_in        (hc),
        .vc_in        (vc),
        .pause        (pause),
        .red          (red2),
        .green        (green2),
        .blue         (blue2),
        .frame_tick   (tick2),
        .bounce_count (bounce2)
    );

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Put a pixel coordinate on the counters and check the main instance's colour
    task automatic probe(input string tag, input int h, input int v, input logic [7:0] exp);
        hc = 10'(h);
        vc = 10'(v);
        #1;
        check_val(tag, {red1, green1, blue1}, {24'd0, exp});
    endtask

    // One short frame: leave blank, enter blank (tick), let the tick apply
    task automatic frame();
        vc = 10'd0;
        @(posedge clk); #1;
        vc = 10'd480;
        @(posedge clk); #1;
        vc = 10'd0;
        @(posedge clk); #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int extra;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        check_val("rst_tick", tick1, 0);
        check_val("rst_bounce", bounce1, 0);
        probe("rst_px_0_0", 0, 0, 8'hE0);
        probe("rst_px_31_31", 31, 31, 8'hE0);
        probe("rst_px_32_0", 32, 0, 8'h02);
        probe("rst_px_0_32", 0, 32, 8'h02);
        probe("rst_px_h700", 700, 0, 8'h00);
        probe("rst_px_v500", 0, 500, 8'h00);

        // First tick: one cycle after vc reaches 480, exactly once
        hc = 10'd0;
        vc = 10'd479;
        @(posedge clk); #1;
        check_val("tick_before", tick1, 0);
        vc = 10'd480;
        @(posedge clk); #1;
        check_val("tick_pulse", tick1, 1);
        extra = 0;
        repeat (800) begin
            @(posedge clk); #1;
            if (tick1) extra++;
        end
        check_val("tick_once", extra, 0);
        check_val("t1_box_x", dut1.box_x_q, 2);
        check_val("t1_box_y", dut1.box_y_q, 2);
        probe("t1_px_1_2", 1, 2, 8'h02);
        probe("t1_px_2_2", 2, 2, 8'hE0);
        probe("t1_px_33_33", 33, 33, 8'hE0);
        probe("t1_px_34_2", 34, 2, 8'h02);

        // Run to the right wall; y hits the bottom on the way (tick 224)
        for (int t = 2; t <= 304; t++) begin
            frame();
            if (t == 224) begin
                check_val("t224_y_bounce", bounce1, 1);
                check_val("t224_y_dir", dut1.dir_y_q, 1);
                check_val("corner_x", dut2.box_x_q, 448);
                check_val("corner_y", dut2.box_y_q, 448);
                check_val("corner_dirx", dut2.dir_x_q, 1);
                check_val("corner_diry", dut2.dir_y_q, 1);
                check_val("corner_bounce", bounce2, 1);
                check_val("corner_flash", dut2.flash_cnt_q, 8);
                hc = 10'd448;
                vc = 10'd448;
                #1;
                check_val("corner_px", {red2, green2, blue2}, 32'hFF);
            end
        end
        check_val("wall_x", dut1.box_x_q, 608);
        check_val("wall_dirx", dut1.dir_x_q, 1);
        check_val("wall_bounce", bounce1, 2);
        probe("wall_px_flash", 608, 288, 8'hFF);
        probe("wall_px_left", 607, 288, 8'h02);

        // Flash lasts 8 frames after the hit, then the normal colour returns
        for (int k = 1; k <= 8; k++) begin
            frame();
            if (k == 1) begin
                check_val("wall_x_back", dut1.box_x_q, 606);
                probe("flash_k1", 606, 286, 8'hFF);
            end
            if (k == 7) probe("flash_k7", 594, 274, 8'hFF);
            if (k == 8) probe("flash_k8_done", 592, 272, 8'hE0);
        end

        // Continue to the top wall so the pause test starts while flashing
        for (int t = 313; t <= 448; t++) frame();
        check_val("top_y", dut1.box_y_q, 0);
        check_val("top_x", dut1.box_x_q, 320);
        check_val("top_bounce", bounce1, 3);
        check_val("top_flash", dut1.flash_cnt_q, 8);
        check_val("corner2_bounce", bounce2, 2);

        // Paused across three ticks: frozen, flash still counts down
        pause = 1'b1;
        repeat (3) frame();
        check_val("pause_x", dut1.box_x_q, 320);
        check_val("pause_y", dut1.box_y_q, 0);
        check_val("pause_flash", dut1.flash_cnt_q, 5);
        check_val("pause_bounce", bounce1, 3);
        probe("pause_px", 320, 0, 8'hFF);

        // Resume tick moves the square
        pause = 1'b0;
        frame();
        check_val("resume_x", dut1.box_x_q, 318);
        check_val("resume_y", dut1.box_y_q, 2);
        check_val("resume_flash", dut1.flash_cnt_q, 4);
        probe("resume_px_in", 318, 2, 8'hFF);
        probe("resume_px_out", 317, 2, 8'h02);

        // A pause pulse between ticks is ignored
        @(posedge clk); #1;
        pause = 1'b1;
        @(posedge clk); #1;
        pause = 1'b0;
        frame();
        check_val("pulse_x", dut1.box_x_q, 316);
        check_val("pulse_y", dut1.box_y_q, 4);

        // Mid-frame reset while flashing
        check_val("pre_rst_flash", dut1.flash_cnt_q, 3);
        hc = 10'd0;
        vc = 10'd200;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check_val("mrst_bounce", bounce1, 0);
        check_val("mrst_tick", tick1, 0);
        check_val("mrst_x", dut1.box_x_q, 0);
        check_val("mrst_y", dut1.box_y_q, 0);
        probe("mrst_px", 0, 0, 8'hE0);
        vc = 10'd200;
        extra = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (tick1) extra++;
        end
        check_val("mrst_no_tick", extra, 0);
        vc = 10'd480;
        @(posedge clk); #1;
        check_val("mrst_tick_480", tick1, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
